// File: rtl/noc_credit_link.sv
// noc_credit_link: per-channel pipelined flit/credit link with an upstream credit monitor and sticky error flags
module noc_credit_link #(
  parameter int NUM_CHANNELS      = 4,
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 4,
  parameter int NUM_PIPELINE      = 2,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0] data_in,
  input  logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0] dest_in,
  input  logic [NUM_CHANNELS-1:0]                is_tail_in,
  input  logic [NUM_CHANNELS-1:0]                send_in,
  output logic [NUM_CHANNELS-1:0]                credit_out,
  output logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0] data_out,
  output logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0] dest_out,
  output logic [NUM_CHANNELS-1:0]                is_tail_out,
  output logic [NUM_CHANNELS-1:0]                send_out,
  input  logic [NUM_CHANNELS-1:0]                credit_in,
  input  logic                                   err_clear,
  output logic [NUM_CHANNELS-1:0][CNT_WIDTH-1:0] credit_count,
  output logic [NUM_CHANNELS-1:0]                err_no_credit,
  output logic [NUM_CHANNELS-1:0]                err_overflow
);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(FLIT_BUFFER_DEPTH);
  generate
    if (NUM_PIPELINE == 0) begin : g_pass
      assign data_out    = data_in;
      assign dest_out    = dest_in;
      assign is_tail_out = is_tail_in;
      assign send_out    = send_in;
      assign credit_out  = credit_in;
    end else begin : g_pipe
      logic [NUM_PIPELINE-1:0][NUM_CHANNELS-1:0][FLIT_WIDTH-1:0] data_q;
      logic [NUM_PIPELINE-1:0][NUM_CHANNELS-1:0][DEST_WIDTH-1:0] dest_q;
      logic [NUM_PIPELINE-1:0][NUM_CHANNELS-1:0]                 tail_q;
      logic [NUM_PIPELINE-1:0][NUM_CHANNELS-1:0]                 send_q;
      logic [NUM_PIPELINE-1:0][NUM_CHANNELS-1:0]                 credit_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          data_q   <= '0;
          dest_q   <= '0;
          tail_q   <= '0;
          send_q   <= '0;
          credit_q <= '0;
        end else begin
          data_q[0]   <= data_in;
          dest_q[0]   <= dest_in;
          tail_q[0]   <= is_tail_in;
          send_q[0]   <= send_in;
          credit_q[0] <= credit_in;
          for (int s = 1; s < NUM_PIPELINE; s++) begin
            data_q[s]   <= data_q[s-1];
            dest_q[s]   <= dest_q[s-1];
            tail_q[s]   <= tail_q[s-1];
            send_q[s]   <= send_q[s-1];
            credit_q[s] <= credit_q[s-1];
          end
        end
      assign data_out    = data_q[NUM_PIPELINE-1];
      assign dest_out    = dest_q[NUM_PIPELINE-1];
      assign is_tail_out = tail_q[NUM_PIPELINE-1];
      assign send_out    = send_q[NUM_PIPELINE-1];
      assign credit_out  = credit_q[NUM_PIPELINE-1];
    end
  endgenerate
  // A send and a returning credit in the same cycle cancel, so neither can violate.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      credit_count  <= {NUM_CHANNELS{MAX_CNT}};
      err_no_credit <= '0;
      err_overflow  <= '0;
    end else begin
      if (err_clear) begin
        err_no_credit <= '0;
        err_overflow  <= '0;
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (send_in[c] && !credit_out[c]) begin
          if (credit_count[c] == '0) err_no_credit[c] <= 1'b1;
          else credit_count[c] <= credit_count[c] - CNT_WIDTH'(1);
        end
        if (credit_out[c] && !send_in[c]) begin
          if (credit_count[c] == MAX_CNT) err_overflow[c] <= 1'b1;
          else credit_count[c] <= credit_count[c] + CNT_WIDTH'(1);
        end
      end
    end
endmodule

// File: tb/tb_noc_credit_link.sv
// tb_noc_credit_link: directed checks of a 2-stage link and a 0-stage passthrough link sharing stimulus
module tb_noc_credit_link;
  localparam int NC = 4, FW = 128, DW = 4, CW = 2;
  logic clk = 0, rst = 1, err_clear = 0;
  logic [NC-1:0][FW-1:0] data_in;
  logic [NC-1:0][DW-1:0] dest_in;
  logic [NC-1:0] is_tail_in, send_in, credit_in;
  logic [NC-1:0][FW-1:0] data_out, data_out0;
  logic [NC-1:0][DW-1:0] dest_out, dest_out0;
  logic [NC-1:0] is_tail_out, send_out, credit_out, err_no_credit, err_overflow;
  logic [NC-1:0] is_tail_out0, send_out0, credit_out0, err_no_credit0, err_overflow0;
  logic [NC-1:0][CW-1:0] credit_count, credit_count0;
  int n_cmp = 0, n_err = 0;
  logic [FW-1:0] pat;

  always #5 clk = ~clk;

  noc_credit_link #(.NUM_PIPELINE(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
    .send_in(send_in), .credit_out(credit_out), .data_out(data_out), .dest_out(dest_out),
    .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in), .err_clear(err_clear),
    .credit_count(credit_count), .err_no_credit(err_no_credit), .err_overflow(err_overflow));

  noc_credit_link #(.NUM_PIPELINE(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
    .send_in(send_in), .credit_out(credit_out0), .data_out(data_out0), .dest_out(dest_out0),
    .is_tail_out(is_tail_out0), .send_out(send_out0), .credit_in(credit_in), .err_clear(err_clear),
    .credit_count(credit_count0), .err_no_credit(err_no_credit0), .err_overflow(err_overflow0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    data_in = '0; dest_in = '0; is_tail_in = '0; send_in = '0; credit_in = '0; err_clear = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (credit_count !== {NC{2'd2}}) begin n_err++; $display("FAIL reset_count got %h exp %h", credit_count, {NC{2'd2}}); end
    n_cmp++; if ({err_no_credit, err_overflow} !== 8'h00) begin n_err++; $display("FAIL reset_err got %h exp 00", {err_no_credit, err_overflow}); end
    n_cmp++; if ({send_out, credit_out} !== 8'h00) begin n_err++; $display("FAIL reset_outs got %h exp 00", {send_out, credit_out}); end
  endtask

  task automatic test_forward();
    do_reset();
    pat = {16{8'hA5}};
    send_in = 4'b0001; data_in[0] = pat; dest_in[0] = 4'd3; is_tail_in = 4'b0001;
    step();
    clear_inputs();
    n_cmp++; if (send_out !== 4'b0000) begin n_err++; $display("FAIL fwd_early got %b exp 0000", send_out); end
    step();
    n_cmp++; if (send_out !== 4'b0001) begin n_err++; $display("FAIL fwd_send got %b exp 0001", send_out); end
    n_cmp++; if (data_out[0] !== pat) begin n_err++; $display("FAIL fwd_data got %h exp %h", data_out[0], pat); end
    n_cmp++; if (dest_out[0] !== 4'd3) begin n_err++; $display("FAIL fwd_dest got %h exp 3", dest_out[0]); end
    n_cmp++; if (is_tail_out[0] !== 1'b1) begin n_err++; $display("FAIL fwd_tail got %b exp 1", is_tail_out[0]); end
    n_cmp++; if (credit_count[0] !== 2'd1) begin n_err++; $display("FAIL fwd_count got %0d exp 1", credit_count[0]); end
    step();
    n_cmp++; if (send_out !== 4'b0000) begin n_err++; $display("FAIL fwd_late got %b exp 0000", send_out); end
  endtask

  task automatic test_no_credit();
    do_reset();
    send_in = 4'b0010;
    step();
    n_cmp++; if (credit_count[1] !== 2'd1) begin n_err++; $display("FAIL nc_cnt1 got %0d exp 1", credit_count[1]); end
    step();
    n_cmp++; if (credit_count[1] !== 2'd0) begin n_err++; $display("FAIL nc_cnt0 got %0d exp 0", credit_count[1]); end
    n_cmp++; if (err_no_credit !== 4'b0000) begin n_err++; $display("FAIL nc_early_err got %b exp 0000", err_no_credit); end
    step();
    send_in = '0;
    n_cmp++; if (err_no_credit !== 4'b0010) begin n_err++; $display("FAIL nc_err got %b exp 0010", err_no_credit); end
    n_cmp++; if (credit_count[1] !== 2'd0) begin n_err++; $display("FAIL nc_hold got %0d exp 0", credit_count[1]); end
    step();
    step();
    n_cmp++; if (err_no_credit !== 4'b0010) begin n_err++; $display("FAIL nc_sticky got %b exp 0010", err_no_credit); end
  endtask

  task automatic test_coincide();
    do_reset();
    send_in = 4'b0100; credit_in = 4'b0100;
    step();
    credit_in = '0;
    n_cmp++; if (credit_count[2] !== 2'd1) begin n_err++; $display("FAIL co_cnt1 got %0d exp 1", credit_count[2]); end
    step();
    n_cmp++; if (credit_count[2] !== 2'd0) begin n_err++; $display("FAIL co_cnt0 got %0d exp 0", credit_count[2]); end
    n_cmp++; if (credit_out !== 4'b0100) begin n_err++; $display("FAIL co_credit got %b exp 0100", credit_out); end
    step();
    send_in = '0;
    n_cmp++; if (credit_count[2] !== 2'd0) begin n_err++; $display("FAIL co_cnt got %0d exp 0", credit_count[2]); end
    n_cmp++; if (err_no_credit[2] !== 1'b0) begin n_err++; $display("FAIL co_err got %b exp 0", err_no_credit[2]); end
  endtask

  task automatic test_overflow();
    do_reset();
    credit_in = 4'b1000;
    step();
    credit_in = '0;
    n_cmp++; if (credit_out !== 4'b0000) begin n_err++; $display("FAIL ov_early got %b exp 0000", credit_out); end
    step();
    n_cmp++; if (credit_out !== 4'b1000) begin n_err++; $display("FAIL ov_credit got %b exp 1000", credit_out); end
    step();
    n_cmp++; if (err_overflow !== 4'b1000) begin n_err++; $display("FAIL ov_err got %b exp 1000", err_overflow); end
    n_cmp++; if (credit_count[3] !== 2'd2) begin n_err++; $display("FAIL ov_cnt got %0d exp 2", credit_count[3]); end
    err_clear = 1;
    step();
    err_clear = 0;
    n_cmp++; if (err_overflow !== 4'b0000) begin n_err++; $display("FAIL ov_clear got %b exp 0000", err_overflow); end
    credit_in = 4'b1000;
    step();
    credit_in = '0;
    step();
    err_clear = 1;
    step();
    err_clear = 0;
    n_cmp++; if (err_overflow !== 4'b1000) begin n_err++; $display("FAIL ov_clear_vs_set got %b exp 1000", err_overflow); end
  endtask

  task automatic test_passthrough();
    do_reset();
    send_in = 4'b1010; credit_in = 4'b0101; data_in[1] = 128'h1234; dest_in[1] = 4'd9;
    #1;
    n_cmp++; if (send_out0 !== 4'b1010) begin n_err++; $display("FAIL p0_send got %b exp 1010", send_out0); end
    n_cmp++; if (credit_out0 !== 4'b0101) begin n_err++; $display("FAIL p0_credit got %b exp 0101", credit_out0); end
    n_cmp++; if (data_out0[1] !== 128'h1234 || dest_out0[1] !== 4'd9) begin n_err++; $display("FAIL p0_fields got %h/%h exp 1234/9", data_out0[1], dest_out0[1]); end
    step();
    clear_inputs();
    n_cmp++; if (credit_count0 !== {2'd1, 2'd2, 2'd1, 2'd2}) begin n_err++; $display("FAIL p0_count got %h exp 66", credit_count0); end
    n_cmp++; if (err_overflow0 !== 4'b0101) begin n_err++; $display("FAIL p0_ovf got %b exp 0101", err_overflow0); end
    n_cmp++; if (err_no_credit0 !== 4'b0000) begin n_err++; $display("FAIL p0_nc got %b exp 0000", err_no_credit0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_in = 4'b1111; credit_in = 4'b1111;
    step();
    step();
    n_cmp++; if (send_out !== 4'b1111 || credit_count !== 8'h00) begin n_err++; $display("FAIL rm_pre got %b/%h exp 1111/00", send_out, credit_count); end
    clear_inputs();
    rst = 1;
    #1;
    n_cmp++; if ({send_out, credit_out} !== 8'h00) begin n_err++; $display("FAIL rm_outs got %h exp 00", {send_out, credit_out}); end
    n_cmp++; if (credit_count !== {NC{2'd2}}) begin n_err++; $display("FAIL rm_count got %h exp aa", credit_count); end
    n_cmp++; if ({err_no_credit, err_overflow} !== 8'h00) begin n_err++; $display("FAIL rm_err got %h exp 00", {err_no_credit, err_overflow}); end
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({send_out, credit_out, err_no_credit, err_overflow} !== 16'h0 || credit_count !== {NC{2'd2}}) begin
        n_err++; $display("FAIL rm_post%0d got %h/%h exp 0000/aa", i, {send_out, credit_out, err_no_credit, err_overflow}, credit_count);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forward();
    test_no_credit();
    test_coincide();
    test_overflow();
    test_passthrough();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/noc_credit_link.md
Name: noc_credit_link

Overview:
- Multi-channel, parametrised pipelined NoC link placed between a router output port group and the neighbouring router's input ports.
- Each channel carries the flit bundle (data, dest, is_tail, send) forward and credit backward, each through NUM_PIPELINE register stages.
- An upstream-side credit monitor tracks downstream buffer occupancy per channel. It flags protocol violations (send without credit, credit overflow) with sticky per-channel error bits.

Parameters:
- NUM_CHANNELS, 4, number of independent links (one per router mesh port).
- FLIT_WIDTH, 128, flit data width.
- DEST_WIDTH, 4, destination field width.
- NUM_PIPELINE, 2, register stages per direction; legal range 0..8; 0 = combinational passthrough, monitor still registered.
- FLIT_BUFFER_DEPTH, 2, downstream input buffer depth; initial credit count; legal ≥1.
- CNT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width (derived, do not override).

Ports:
- clk  input  1  link clock (NoC domain).
- rst  input  1  asynchronous, active-high reset.
- data_in  input  [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0]  upstream flit data.
- dest_in  input  [NUM_CHANNELS-1:0][DEST_WIDTH-1:0]  upstream flit destination.
- is_tail_in  input  [NUM_CHANNELS-1:0]  upstream tail marker.
- send_in  input  [NUM_CHANNELS-1:0]  upstream flit valid.
- credit_out  output  [NUM_CHANNELS-1:0]  credit returned to upstream router.
- data_out  output  [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0]  downstream flit data.
- dest_out  output  [NUM_CHANNELS-1:0][DEST_WIDTH-1:0]  downstream destination.
- is_tail_out  output  [NUM_CHANNELS-1:0]  downstream tail marker.
- send_out  output  [NUM_CHANNELS-1:0]  downstream flit valid.
- credit_in  input  [NUM_CHANNELS-1:0]  credit from downstream router.
- err_clear  input  1  synchronous clear of all sticky error bits.
- credit_count  output  [NUM_CHANNELS-1:0][CNT_WIDTH-1:0]  per-channel credits available at upstream side.
- err_no_credit  output  [NUM_CHANNELS-1:0]  sticky: send issued with zero credits.
- err_overflow  output  [NUM_CHANNELS-1:0]  sticky: credit returned with counter at FLIT_BUFFER_DEPTH.

Behaviour:
- Forward path: send_out[c]/data_out[c]/dest_out[c]/is_tail_out[c] equal the inputs delayed exactly NUM_PIPELINE cycles.
- Backward path: credit_out[c] equals credit_in[c] delayed exactly NUM_PIPELINE cycles.
- Channels are fully independent. Stage registers load every cycle; there is no stall and no bubble removal.
- Data/dest/is_tail stages load unconditionally. Data/dest/is_tail outputs with send_out=0 are don't-care for checking.
- Reset (async assert, synchronous-safe deassert handled externally):
  - all send/credit stage bits = 0; data/dest/is_tail stages = 0;
  - credit_count[c] = FLIT_BUFFER_DEPTH; err bits = 0.
  - With NUM_PIPELINE=0, outputs follow inputs even during reset.
- Credit monitor observes the upstream boundary (send_in, credit_out) each cycle, per channel:
  - send only: if count>0, count−1; else count held, err_no_credit set.
  - credit only: if count<FLIT_BUFFER_DEPTH, count+1; else count held, err_overflow set.
  - both in same cycle: count unchanged, no error. The credit is consumed by the send, so this is legal even at count=0 or at max.
  - neither: hold.
- Counter never wraps. Saturation is paired with the error flag.
- Error bits are sticky until err_clear. If err_clear and a new violation occur in the same cycle, the violation wins (bit = 1).
- Monitor outputs are registered and reflect the update one cycle after the observed event.
- Round-trip credit latency is 2*NUM_PIPELINE. Sizing FLIT_BUFFER_DEPTH for full throughput is the integrator's concern and is not checked.
- Reset mid-packet: in-flight flits and credits are discarded. Counters return to FLIT_BUFFER_DEPTH; no error is raised on the first post-reset cycle.

Test Plan:
- NUM_PIPELINE=2, ch0 send_in=1 with data=0xA5.., dest=3, tail=1 at cycle 10 → send_out[0]=1 with identical fields at cycle 12 only; other channels remain 0.
- FLIT_BUFFER_DEPTH=2: ch1 sends at cycles 5 and 6, no credits → credit_count[1] reads 1 then 0. A third send at cycle 7 → err_no_credit[1]=1 from cycle 8, count stays 0.
- Count=0 on ch2, send_in and credit_out coincide → count stays 0, err_no_credit[2]=0.
- credit_in[3] pulsed with count=2 (max) → credit_out[3] at +2 cycles, then err_overflow[3]=1, count stays 2. err_clear pulse → bit returns to 0 next cycle.
- NUM_PIPELINE=0 → send_out == send_in and credit_out == credit_in in the same cycle; monitor behaves as above.
- Assert rst for 1 cycle while flits are in stages and count=0 → send_out/credit_out = 0 immediately, counts = FLIT_BUFFER_DEPTH, errors = 0, no spurious flits after release.
